// File: rtl/avalon_test_slave.sv
// Avalon-MM test endpoint: peripheral-select decode, byte-enabled register file, programmable wait states.
// Optional build macro AVALON_TEST_SLAVE_ACCESS_CNT_EN turns the top word into a read-only access counter.
module avalon_test_slave #(
    parameter int NUM_PERIPH_SEL_BITS   = 5,
    parameter int PERIPH_SEL            = 0,
    parameter int WRITE_WAIT_REQ_CYCLES = 0,
    parameter int READ_WAIT_REQ_CYCLES  = 0,
    parameter int MEM_ADDR_BITS         = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [29:0] i_AV_Addr,
    input  logic [3:0]  i_AV_ByteEn,
    input  logic        i_AV_Read,
    input  logic        i_AV_Write,
    output logic [31:0] o_AV_ReadData,
    input  logic [31:0] i_AV_WriteData,
    output logic        o_AV_WaitRequest
);
    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam logic [NUM_PERIPH_SEL_BITS-1:0] SEL_VAL = NUM_PERIPH_SEL_BITS'(PERIPH_SEL);
    localparam logic [7:0] WR_N = 8'(WRITE_WAIT_REQ_CYCLES);
    localparam logic [7:0] RD_N = 8'(READ_WAIT_REQ_CYCLES);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                     state_q, state_d;
    logic [7:0]                 cnt_q, cnt_d;
    logic [31:0]                mem_q [DEPTH];
    logic                       sel, wr_req, rd_req, req;
    logic [7:0]                 n_wait, eff_cnt;
    logic                       wait_now, wr_done, rd_done, mem_we;
    logic [MEM_ADDR_BITS-1:0]   idx;
    logic [31:0]                rd_word, rd_data;
    logic                       unused_addr_bits;

    // Read+write together is treated as a write; the bits between select and index alias.
    assign sel     = (i_AV_Addr[29 -: NUM_PERIPH_SEL_BITS] == SEL_VAL);
    assign idx     = i_AV_Addr[MEM_ADDR_BITS-1:0];
    assign wr_req  = sel && i_AV_Write;
    assign rd_req  = sel && i_AV_Read && !i_AV_Write;
    assign req     = wr_req || rd_req;
    assign n_wait  = wr_req ? WR_N : RD_N;
    assign eff_cnt = (state_q == ST_WAIT) ? cnt_q : 8'd0;
    assign unused_addr_bits = ^i_AV_Addr;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        if (req && (eff_cnt < n_wait)) begin
            state_d = ST_WAIT;
            cnt_d   = eff_cnt + 8'd1;
        end
    end

    always_comb begin
        wait_now = 1'b0;
        wr_done  = 1'b0;
        rd_done  = 1'b0;
        rd_data  = 32'd0;
        if (req) begin
            if (eff_cnt < n_wait) begin
                wait_now = 1'b1;
            end else begin
                wr_done = wr_req;
                rd_done = rd_req;
                if (rd_req) rd_data = rd_word;
            end
        end
    end

    assign o_AV_WaitRequest = wait_now;
    assign o_AV_ReadData    = rd_data;

`ifdef AVALON_TEST_SLAVE_ACCESS_CNT_EN
    localparam logic [MEM_ADDR_BITS-1:0] CNT_IDX = '1;
    logic [15:0] wr_cnt_q, rd_cnt_q;

    assign rd_word = (idx == CNT_IDX) ? {rd_cnt_q, wr_cnt_q} : mem_q[idx];
    assign mem_we  = wr_done && (idx != CNT_IDX);

    // Counted on the completing edge, so a read of the counter sees the pre-increment value.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            wr_cnt_q <= 16'd0;
            rd_cnt_q <= 16'd0;
        end else begin
            if (wr_done) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (rd_done) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end
`else
    assign rd_word = mem_q[idx];
    assign mem_we  = wr_done;
`endif

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_AV_ByteEn[b]) mem_q[idx][8*b +: 8] <= i_AV_WriteData[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_avalon_test_slave.sv
// Two slaves share one bus (select 0: no waits; select 1: 3 write / 2 read waits) and are
// checked every cycle against a transaction-level model of the register files.
module tb_avalon_test_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] addr;
    logic [3:0]  be;
    logic        rd, wr;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
    logic        wait0, wait1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    avalon_test_slave #(
        .NUM_PERIPH_SEL_BITS(5), .PERIPH_SEL(0),
        .WRITE_WAIT_REQ_CYCLES(0), .READ_WAIT_REQ_CYCLES(0), .MEM_ADDR_BITS(4)
    ) dut0 (
        .i_Clk(clk), .i_Rst(rst), .i_AV_Addr(addr), .i_AV_ByteEn(be),
        .i_AV_Read(rd), .i_AV_Write(wr), .o_AV_ReadData(rdata0),
        .i_AV_WriteData(wdata), .o_AV_WaitRequest(wait0)
    );

    avalon_test_slave #(
        .NUM_PERIPH_SEL_BITS(5), .PERIPH_SEL(1),
        .WRITE_WAIT_REQ_CYCLES(3), .READ_WAIT_REQ_CYCLES(2), .MEM_ADDR_BITS(4)
    ) dut1 (
        .i_Clk(clk), .i_Rst(rst), .i_AV_Addr(addr), .i_AV_ByteEn(be),
        .i_AV_Read(rd), .i_AV_Write(wr), .o_AV_ReadData(rdata1),
        .i_AV_WriteData(wdata), .o_AV_WaitRequest(wait1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem [2][16];
    logic [15:0] m_wrc [2];
    logic [15:0] m_rdc [2];
    int          m_elapsed [2];

    function automatic int wn(input int s);
        return (s == 0) ? 0 : 3;
    endfunction

    function automatic int rn(input int s);
        return (s == 0) ? 0 : 2;
    endfunction

    function automatic int dec(input logic [29:0] a);
        if (a[29:25] == 5'd0) return 0;
        if (a[29:25] == 5'd1) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] m_word(input int s, input int i);
`ifdef AVALON_TEST_SLAVE_ACCESS_CNT_EN
        if (i == 15) return {m_rdc[s], m_wrc[s]};
`endif
        return m_mem[s][i];
    endfunction

    function automatic bool_is_cnt(input int i);
`ifdef AVALON_TEST_SLAVE_ACCESS_CNT_EN
        return (i == 15);
`else
        return (i < 0);
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < 16; i++) m_mem[s][i] = 32'd0;
                m_wrc[s] = 16'd0;
                m_rdc[s] = 16'd0;
                m_elapsed[s] = 0;
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if ((rd || wr) && dec(addr) == s) begin
                    if (m_elapsed[s] < (wr ? wn(s) : rn(s))) begin
                        m_elapsed[s]++;
                    end else begin
                        m_elapsed[s] = 0;
                        if (wr) begin
                            m_wrc[s] = m_wrc[s] + 16'd1;
                            if (!bool_is_cnt(int'(addr[3:0]))) begin
                                for (int b = 0; b < 4; b++)
                                    if (be[b]) m_mem[s][addr[3:0]][8*b +: 8] = wdata[8*b +: 8];
                            end
                        end else begin
                            m_rdc[s] = m_rdc[s] + 16'd1;
                        end
                    end
                end else begin
                    m_elapsed[s] = 0;
                end
            end
        end
    end

    // Per-cycle comparison of both slaves against the model.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            logic        ew;
            logic [31:0] ed;
            ew = 1'b0;
            ed = 32'd0;
            if ((rd || wr) && dec(addr) == s) begin
                if (m_elapsed[s] < (wr ? wn(s) : rn(s))) ew = 1'b1;
                else if (!wr) ed = m_word(s, int'(addr[3:0]));
            end
            check($sformatf("cyc_wait_s%0d", s), 32'(s == 0 ? wait0 : wait1), 32'(ew));
            check($sformatf("cyc_rdata_s%0d", s), (s == 0) ? rdata0 : rdata1, ed);
        end
    end

    // ---------------- driver ----------------
    task automatic access(input logic [4:0] sel, input logic r, input logic w,
                          input logic [3:0] idx, input logic [3:0] bytes,
                          input logic [31:0] d, input int abort_after,
                          output logic [31:0] got, output int waits);
        logic done, aborted;
        addr  = {sel, 21'($urandom), idx};
        rd    = r;
        wr    = w;
        be    = bytes;
        wdata = d;
        waits = 0;
        got   = 32'd0;
        done  = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < 300 && !done && !aborted; k++) begin
            @(negedge clk);
            if (wait0 || wait1) begin
                waits++;
                if (waits == abort_after) aborted = 1'b1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end else begin
                got  = rdata0 | rdata1;
                done = 1'b1;
            end
        end
        if (!done && !aborted) check("access_timeout", 32'(waits), 32'd0);
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic idle(input int n);
        rd = 1'b0;
        wr = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] got;
        int          waits;

        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; be = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_wait", 32'(wait0 | wait1), 32'd0);
        check("reset_rdata", rdata0 | rdata1, 32'd0);
        @(posedge clk);
        #1;

        // Zero-wait slave: write then read next cycle.
        access(5'd0, 0, 1, 4'd0, 4'hF, 32'h5A5A5A5A, -1, got, waits);
        check("s0_write_waits", 32'(waits), 32'd0);
        access(5'd0, 1, 0, 4'd0, 4'h3, 32'h0, -1, got, waits);
        check("s0_read_waits", 32'(waits), 32'd0);
        check("s0_read_data", got, 32'h5A5A5A5A);

        // Partial byte enables.
        access(5'd0, 0, 1, 4'd1, 4'hF, 32'hFFFFFFFF, -1, got, waits);
        access(5'd0, 0, 1, 4'd1, 4'b0101, 32'h00000000, -1, got, waits);
        access(5'd0, 1, 0, 4'd1, 4'h0, 32'h0, -1, got, waits);
        check("byteen_data", got, 32'hFF00FF00);

        // Wait-state slave.
        access(5'd1, 0, 1, 4'd2, 4'hF, 32'hCAFEF00D, -1, got, waits);
        check("s1_write_waits", 32'(waits), 32'd3);
        access(5'd1, 1, 0, 4'd2, 4'hF, 32'h0, -1, got, waits);
        check("s1_read_waits", 32'(waits), 32'd2);
        check("s1_read_data", got, 32'hCAFEF00D);

        // Unselected and foreign-select writes leave other slaves untouched.
        access(5'd7, 0, 1, 4'd0, 4'hF, 32'hDEADBEEF, -1, got, waits);
        check("unsel_waits", 32'(waits), 32'd0);
        access(5'd0, 1, 0, 4'd0, 4'hF, 32'h0, -1, got, waits);
        check("unsel_s0_kept", got, 32'h5A5A5A5A);
        access(5'd1, 1, 0, 4'd0, 4'hF, 32'h0, -1, got, waits);
        check("s1_idx0_zero", got, 32'h0);

        // Read and write together acts as a write with write wait count.
        access(5'd1, 1, 1, 4'd5, 4'hF, 32'h0BADF00D, -1, got, waits);
        check("rw_waits", 32'(waits), 32'd3);
        check("rw_rdata", got, 32'h0);
        access(5'd1, 1, 0, 4'd5, 4'hF, 32'h0, -1, got, waits);
        check("rw_stored", got, 32'h0BADF00D);

        // Reset clears the register file.
        access(5'd0, 0, 1, 4'd3, 4'hF, 32'h12345678, -1, got, waits);
        access(5'd0, 1, 0, 4'd3, 4'hF, 32'h0, -1, got, waits);
        check("pre_reset_data", got, 32'h12345678);
        do_reset();
        access(5'd0, 1, 0, 4'd3, 4'hF, 32'h0, -1, got, waits);
        check("post_reset_data", got, 32'h0);

`ifdef AVALON_TEST_SLAVE_ACCESS_CNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) access(5'd0, 0, 1, 4'(i + 4), 4'hF, $urandom, -1, got, waits);
        for (int i = 0; i < 2; i++) access(5'd0, 1, 0, 4'(i + 4), 4'hF, 32'h0, -1, got, waits);
        access(5'd0, 1, 0, 4'd15, 4'hF, 32'h0, -1, got, waits);
        check("access_counter", got, 32'h00020003);
`endif

        // Reset asserted in the second wait cycle of a read restarts the count.
        access(5'd1, 0, 1, 4'd2, 4'hF, 32'hA5A5A5A5, -1, got, waits);
        addr = {5'd1, 21'd0, 4'd2};
        rd = 1'b1;
        wr = 1'b0;
        @(negedge clk);
        check("rstwait_first", 32'(wait1), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("rstwait_second", 32'(wait1), 32'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        waits = 0;
        got = 32'hFFFFFFFF;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (wait1) begin
                waits++;
                @(posedge clk);
                #1;
            end else begin
                got = rdata1;
                break;
            end
        end
        check("rstwait_restart", 32'(waits), 32'd2);
        check("rstwait_data", got, 32'h0);
        @(posedge clk);
        #1 rd = 1'b0;

        // Randomized traffic, including dropped requests and back-to-back accesses.
        for (int t = 0; t < 300; t++) begin
            logic [4:0] sel;
            int         op, sc, ab;
            sc  = $urandom_range(0, 9);
            sel = (sc < 4) ? 5'd0 : (sc < 8) ? 5'd1 : 5'($urandom_range(2, 31));
            op  = $urandom_range(0, 4);
            ab  = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : -1;
            access(sel, op != 2 && op != 3, op >= 2, 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), $urandom, ab, got, waits);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
